// File: rtl/simbus_mem_arbiter_if.sv
// Channel cmd/rsp buses plus the RAMHelper-style port of the simulation memory front-end.
// The arbiter uses the slave modport; the simulation top (or bench) uses master.
interface simbus_mem_arbiter_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = 28
);
    logic [NUM_CH-1:0]    ch_cmd_valid;
    logic [NUM_CH-1:0]    ch_cmd_ready;
    logic [NUM_CH*64-1:0] ch_cmd_addr;
    logic [NUM_CH-1:0]    ch_cmd_wen;
    logic [NUM_CH*64-1:0] ch_cmd_wdata;
    logic [NUM_CH*8-1:0]  ch_cmd_wstrb;
    logic [NUM_CH-1:0]    ch_rsp_valid;
    logic [NUM_CH*64-1:0] ch_rsp_data;
    logic [NUM_CH-1:0]    ch_rsp_err;

    logic                 ram_en;
    logic [IDX_W-1:0]     ram_ridx;
    logic [63:0]          ram_rdata;
    logic [IDX_W-1:0]     ram_widx;
    logic [63:0]          ram_wdata;
    logic [63:0]          ram_wmask;
    logic                 ram_wen;

    modport slave (
        input  ch_cmd_valid, ch_cmd_addr, ch_cmd_wen, ch_cmd_wdata, ch_cmd_wstrb, ram_rdata,
        output ch_cmd_ready, ch_rsp_valid, ch_rsp_data, ch_rsp_err,
        output ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen
    );

    modport master (
        output ch_cmd_valid, ch_cmd_addr, ch_cmd_wen, ch_cmd_wdata, ch_cmd_wstrb, ram_rdata,
        input  ch_cmd_ready, ch_rsp_valid, ch_rsp_data, ch_rsp_err,
        input  ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen
    );
endinterface

// File: rtl/simbus_mem_arbiter.sv
// Round-robin arbiter of NUM_CH cmd/rsp channels onto one RAMHelper port, with a
// LATENCY-deep tagged response pipeline and out-of-range error flagging.
module simbus_mem_arbiter #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned IDX_W     = 28,
    parameter bit          WRITE_ACK = 1'b0
) (
    input logic                 clock,
    input logic                 reset,
    simbus_mem_arbiter_if.slave bus
);
    localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ID_W-1:0] ptr_q;
    logic            grant;
    logic [ID_W-1:0] grant_id;
    logic            active;
    int unsigned     cand;

    logic [63:0]      sel_addr;
    logic [63:0]      sel_wdata;
    logic [7:0]       sel_wstrb;
    logic             sel_wen;
    logic [63:0]      off;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    logic            stg_valid_q [LATENCY];
    logic [ID_W-1:0] stg_id_q    [LATENCY];
    logic [63:0]     stg_data_q  [LATENCY];
    logic            stg_err_q   [LATENCY];
    logic [63:0]     hold_q      [NUM_CH];
    logic            last_valid;

    // First valid channel after the pointer, wrapping modulo NUM_CH.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = (32'(ptr_q) + k) % NUM_CH;
            if (!grant && bus.ch_cmd_valid[ID_W'(cand)]) begin
                grant    = 1'b1;
                grant_id = ID_W'(cand);
            end
        end
    end

    assign active    = grant & ~reset;
    assign sel_addr  = bus.ch_cmd_addr[{grant_id, 6'b0} +: 64];
    assign sel_wdata = bus.ch_cmd_wdata[{grant_id, 6'b0} +: 64];
    assign sel_wstrb = bus.ch_cmd_wstrb[{grant_id, 3'b0} +: 8];
    assign sel_wen   = bus.ch_cmd_wen[grant_id];

    assign off      = sel_addr - BASE_ADDR;
    assign idx      = off[IDX_W+2:3];
    assign in_range = (sel_addr >= BASE_ADDR) && ((off >> (IDX_W + 3)) == 64'd0);

    always_comb begin
        bus.ch_cmd_ready = '0;
        if (active) begin
            bus.ch_cmd_ready = NUM_CH'(1) << grant_id;
        end
    end

    assign bus.ram_en    = active & in_range;
    assign bus.ram_wen   = active & sel_wen & in_range;
    assign bus.ram_ridx  = idx;
    assign bus.ram_widx  = idx;
    assign bus.ram_wdata = sel_wdata;

    always_comb begin
        bus.ram_wmask = '0;
        for (int k = 0; k < 8; k++) begin
            bus.ram_wmask[k*8 +: 8] = {8{sel_wstrb[k]}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= ID_W'(NUM_CH - 1);
            for (int s = 0; s < LATENCY; s++) begin
                stg_valid_q[s] <= 1'b0;
                stg_id_q[s]    <= '0;
                stg_data_q[s]  <= '0;
                stg_err_q[s]   <= 1'b0;
            end
        end else begin
            if (grant) begin
                ptr_q <= grant_id;
            end
            stg_valid_q[0] <= grant & (~sel_wen | WRITE_ACK);
            stg_id_q[0]    <= grant_id;
            stg_data_q[0]  <= (in_range && !sel_wen) ? bus.ram_rdata : 64'd0;
            stg_err_q[0]   <= ~in_range;
            for (int s = 1; s < LATENCY; s++) begin
                stg_valid_q[s] <= stg_valid_q[s-1];
                stg_id_q[s]    <= stg_id_q[s-1];
                stg_data_q[s]  <= stg_data_q[s-1];
                stg_err_q[s]   <= stg_err_q[s-1];
            end
        end
    end

    assign last_valid = stg_valid_q[LATENCY-1] & ~reset;

    // Channels without a response this cycle keep presenting their last data.
    always_comb begin
        bus.ch_rsp_valid = '0;
        bus.ch_rsp_err   = '0;
        bus.ch_rsp_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (last_valid && (stg_id_q[LATENCY-1] == ID_W'(c))) begin
                bus.ch_rsp_valid[c]       = 1'b1;
                bus.ch_rsp_err[c]         = stg_err_q[LATENCY-1];
                bus.ch_rsp_data[c*64 +: 64] = stg_data_q[LATENCY-1];
            end else if (!reset) begin
                bus.ch_rsp_data[c*64 +: 64] = hold_q[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.ch_rsp_valid[c]) begin
                    hold_q[c] <= stg_data_q[LATENCY-1];
                end
            end
        end
    end
endmodule
